mbssoc_ram_arbiter: RTL
=======================

Name: mbssoc_ram_arbiter

Overview:
Shares the single-port SoC RAM between the core's instruction-fetch port (I) and data load/store port (D).
- Arbitrates per cycle and drives the RAM control, address and write-data lines.
- Accounts for the RAM's one-cycle registered read address and its bidirectional data bus, inserting bus turnaround where required.
- Returns read data to the requester that issued the read.
- Sits between the core's memory ports and the RAM; the top level builds the tristate from the wdata/oe outputs.

Parameters:
ADDR_WIDTH, 32, byte-address width (matches core constant)
DATA_WIDTH, 32, word width
PRIO_MODE, 0, 0 = round-robin; 1 = fixed D priority with starvation guard
STARVE_LIMIT, 4, fixed mode: consecutive I losses before I is forced; range 1..15

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  instruction read request; held with i_addr until i_gnt
i_addr  in  ADDR_WIDTH  fetch byte address, word aligned
i_gnt  out  1  accept pulse for I request (combinational)
i_rvalid  out  1  I read data valid, one-cycle pulse
i_rdata  out  DATA_WIDTH  I read data, held until next i_rvalid
d_req  in  1  data request; held with fields until d_gnt
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_WIDTH  data byte address, word aligned
d_wdata  in  DATA_WIDTH  write data
d_wr_invalid  in  1  squash flag for the write, forwarded to RAM
d_gnt  out  1  accept pulse for D request (combinational)
d_rvalid  out  1  D read data valid, one-cycle pulse
d_rdata  out  DATA_WIDTH  D read data, held until next d_rvalid
ram_re  out  1  RAM read enable (data-phase cycle)
ram_we  out  1  RAM write enable
ram_wr_invalid  out  1  RAM write squash
ram_addr  out  ADDR_WIDTH  RAM byte address (RAM shifts it right by 2)
ram_wdata  out  DATA_WIDTH  value to drive onto RAM data bus
ram_wdata_oe  out  1  bus drive enable; equals ram_we
ram_rdata  in  DATA_WIDTH  RAM data bus sampled value

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; state IDLE.
  - RR pointer = I; starve counter = 0; i_rdata and d_rdata = 0.
  - Any in-flight read is dropped; no rvalid is produced after reset.
- States:
  - IDLE: no read in its data phase.
  - RD: the previous cycle granted a read. Track owner (I/D) in a 1-bit register.
- Address phase, cycle T (grant cycle):
  - ram_addr = granted address.
  - Write grant: ram_we=1, ram_wdata_oe=1, ram_wdata=d_wdata, ram_wr_invalid=d_wr_invalid.
  - Read grant: moves to RD at the end of T.
- Data phase, cycle T+1:
  - ram_re=1.
  - At the end of T+1, capture ram_rdata into the owner's rdata register.
  - Owner's rvalid=1 during T+2. Read latency grant→rvalid = 2 cycles.
- Pipelining:
  - A read may be granted in a RD cycle; throughput is 1 read/cycle.
  - The state remains RD while reads are granted back to back.
  - If no read is granted in a RD cycle, next state = IDLE.
- Turnaround:
  - In RD, write requests are ineligible because ram_re drives the bus. They wait at least one cycle.
  - ram_we and ram_re are never both 1.
- Eligibility: I is eligible if i_req. D is eligible if d_req and (state==IDLE or d_we==0). At most one gnt per cycle.
- PRIO_MODE=0:
  - When both I and D are eligible, grant the port not granted last.
  - The pointer updates on every grant.
- PRIO_MODE=1:
  - D wins by default.
  - The starve counter increments each cycle i_req=1 while d_gnt=1, and clears on i_gnt.
  - When the counter equals STARVE_LIMIT and I is eligible, I wins and the counter clears.
  - The counter saturates at STARVE_LIMIT.
- Idle cycle (no grant): ram_we=0, ram_wdata_oe=0, ram_wr_invalid=0. ram_addr holds its last value.
- Address low 2 bits are passed through unaltered; alignment is the requester's responsibility.

Decomposition:
- Shared constants include: ADDR_WIDTH, DATA_WIDTH, and the state encodings IDLE=0, RD=1.
- Arbitration mux plus RR/starve logic form one sub-module: mbssoc_arb2. Inputs: two eligible bits and mode. Output: one-hot grant. Owns the pointer and counter.
- The top block keeps the FSM, RAM drive and read return.

Test Plan:
1. I-only read, i_addr=0x10, RAM[4]=0xDEADBEEF → i_gnt in T, ram_re in T+1, i_rvalid in T+2 with i_rdata=0xDEADBEEF; d_rvalid stays 0.
2. D write 0x12345678 to 0x20, then D read 0x20 → ram_we=1 in T, ram_wdata_oe=1; read returns 0x12345678 two cycles after its grant.
3. D read then D write requested back to back → write d_gnt delayed one cycle (RD turnaround); ram_re and ram_we never both 1.
4. PRIO_MODE=0, i_req and d_req (reads) held high for 8 cycles → grants alternate I,D,I,D…; 8 rvalids in order, each routed to the correct port.
5. PRIO_MODE=1, STARVE_LIMIT=4, both request continuously → pattern D,D,D,D,I repeating.
6. rst_n low during the T+1 cycle of a read → no rvalid afterwards; all outputs 0 immediately; the next request after release is granted normally.

Source files
------------

// File: rtl/mbssoc_ram_arbiter_pkg.sv
// Shared constants and state encoding for the SoC RAM arbiter.
package mbssoc_ram_arbiter_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RD   = 1'b1
    } state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mbssoc_arb2.sv
// Two-way arbiter: round-robin or fixed D priority with an I starvation guard.
module mbssoc_arb2 #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       elig_i,
    input  logic       elig_d,
    input  logic       i_req,
    input  logic       prio_mode,
    output logic [1:0] gnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic       ptr_d;
    logic [3:0] starve_cnt;

    always_comb begin
        gnt = 2'b00;
        if (elig_i && elig_d) begin
            if (prio_mode) gnt = (starve_cnt == LIMIT) ? 2'b01 : 2'b10;
            else           gnt = ptr_d ? 2'b10 : 2'b01;
        end else if (elig_i) begin
            gnt = 2'b01;
        end else if (elig_d) begin
            gnt = 2'b10;
        end
    end

    // ptr_d = 1 means D has priority on the next contended cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_d      <= 1'b0;
            starve_cnt <= 4'd0;
        end else begin
            if (gnt[0])      ptr_d <= 1'b1;
            else if (gnt[1]) ptr_d <= 1'b0;

            if (gnt[0])
                starve_cnt <= 4'd0;
            else if (i_req && gnt[1] && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/mbssoc_ram_arbiter.sv
// Shares the single-port RAM between fetch (I) and load/store (D) ports,
// handling the registered read address and read-to-write bus turnaround.
module mbssoc_ram_arbiter
    import mbssoc_ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int PRIO_MODE    = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic                  d_wr_invalid,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  ram_re,
    output logic                  ram_we,
    output logic                  ram_wr_invalid,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_wdata_oe,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    state_t                state_q, state_d;
    logic                  owner_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  elig_i, elig_d;
    logic [1:0]            gnt;

    // Grants are held off during reset so every output reads 0 immediately.
    assign elig_i = rst_n & i_req;
    assign elig_d = rst_n & d_req & ((state_q == IDLE) | ~d_we);

    mbssoc_arb2 #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .elig_i   (elig_i),
        .elig_d   (elig_d),
        .i_req    (i_req),
        .prio_mode(PRIO_MODE != 0),
        .gnt      (gnt)
    );

    assign i_gnt = gnt[0];
    assign d_gnt = gnt[1];

    always_comb begin
        state_d        = IDLE;
        ram_we         = 1'b0;
        ram_wr_invalid = 1'b0;
        ram_wdata      = '0;
        ram_addr       = addr_q;
        if (i_gnt) begin
            ram_addr = i_addr;
            state_d  = RD;
        end else if (d_gnt) begin
            ram_addr = d_addr;
            if (d_we) begin
                ram_we         = 1'b1;
                ram_wdata      = d_wdata;
                ram_wr_invalid = d_wr_invalid;
            end else begin
                state_d = RD;
            end
        end
    end

    assign ram_wdata_oe = ram_we;
    assign ram_re       = (state_q == RD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= OWNER_I;
            addr_q   <= '0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            state_q <= state_d;
            if (gnt != 2'b00) addr_q  <= ram_addr;
            if (state_d == RD) owner_q <= d_gnt ? OWNER_D : OWNER_I;
            i_rvalid <= ram_re && (owner_q == OWNER_I);
            d_rvalid <= ram_re && (owner_q == OWNER_D);
            if (ram_re && owner_q == OWNER_I) i_rdata <= ram_rdata;
            if (ram_re && owner_q == OWNER_D) d_rdata <= ram_rdata;
        end
    end

endmodule
